// File: rtl/vs_stream_pkg.sv
// vs_stream_pkg
// Shared definitions for the VS10xx streaming controller: FSM state
// encodings, SCI opcodes and register addresses, the MODE value used for
// init and soft reset, and a helper that assembles a 32-bit SCI write frame.
package vs_stream_pkg;

    typedef enum logic [3:0] {
        ST_RESET_HOLD,
        ST_RESET_WAIT,
        ST_INIT,
        ST_SCI_WAIT,
        ST_SCI_SHIFT,
        ST_DATA_WAIT,
        ST_FETCH,
        ST_DATA_SHIFT,
        ST_PAUSED
    } state_e;

    typedef enum logic [1:0] {
        SH_IDLE,
        SH_PEND,
        SH_RUN,
        SH_TAIL
    } sh_state_e;

    localparam logic [7:0]  SCI_OP_WRITE   = 8'h02;
    localparam logic [7:0]  SCI_OP_READ    = 8'h03;
    localparam logic [7:0]  SCI_REG_MODE   = 8'h00;
    localparam logic [7:0]  SCI_REG_VOL    = 8'h0B;
    // SM_SDINEW | SM_RESET: the same value serves as init and soft reset
    localparam logic [15:0] MODE_INIT      = 16'h0804;
    localparam logic [5:0]  SCI_FRAME_BITS = 6'd32;

    function automatic logic [31:0] sci_write(input logic [7:0] addr, input logic [15:0] val);
        return {SCI_OP_WRITE, addr, val};
    endfunction

endpackage

// File: rtl/vs_spi_shift.sv
// vs_spi_shift
// SCK tick generator plus a 32-bit MSB-first SPI mode-0 shifter.
// A start pulse (accepted only while idle) loads i_data/i_len; the frame
// begins on the next tick with the first bit already on o_si. o_active is
// high from that tick until one tick after the last falling SCK edge, so
// the owner can derive its chip select directly from it.
//   clk, rst_n  : system clock, async active-low reset
//   i_start     : load request (ignored while busy)
//   i_data      : frame, left-justified (bit 31 goes first)
//   i_len       : number of bits to send (1..32)
//   o_tick      : one-clk strobe every CLK_DIV clocks
//   o_busy      : shifter not idle
//   o_active    : chip-select window
//   o_done      : one-clk pulse after the frame window closes
//   o_sck, o_si : SPI pins
module vs_spi_shift
    import vs_stream_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_data,
    input  logic [5:0]  i_len,
    output logic        o_tick,
    output logic        o_busy,
    output logic        o_active,
    output logic        o_done,
    output logic        o_sck,
    output logic        o_si
);

    localparam int DIV_W = $clog2(CLK_DIV);

    sh_state_e          sh_q, sh_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [31:0]        sr_q, sr_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               half_q, half_d;
    logic               sck_q, sck_d;
    logic               si_q, si_d;
    logic               active_q, active_d;
    logic               done_q, done_d;
    logic               tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q     <= SH_IDLE;
            div_q    <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            half_q   <= 1'b0;
            sck_q    <= 1'b0;
            si_q     <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            div_q    <= div_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            sck_q    <= sck_d;
            si_q     <= si_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        sh_d     = sh_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        sck_d    = sck_q;
        si_d     = si_q;
        active_d = active_q;
        done_d   = 1'b0;
        tick     = (div_q == DIV_W'(CLK_DIV - 1));
        div_d    = tick ? '0 : div_q + 1'b1;

        case (sh_q)
            SH_IDLE: begin
                if (i_start) begin
                    sr_d  = i_data;
                    cnt_d = i_len;
                    sh_d  = SH_PEND;
                end
            end
            SH_PEND: begin
                if (tick) begin
                    si_d     = sr_q[31];
                    sck_d    = 1'b0;
                    half_d   = 1'b0;
                    active_d = 1'b1;
                    sh_d     = SH_RUN;
                end
            end
            SH_RUN: begin
                if (tick) begin
                    if (!half_q) begin
                        sck_d  = 1'b1;
                        half_d = 1'b1;
                    end else begin
                        // Falling edge: present the next bit, or close after the last one
                        sck_d  = 1'b0;
                        half_d = 1'b0;
                        if (cnt_q == 6'd1) begin
                            sh_d = SH_TAIL;
                        end else begin
                            sr_d  = sr_q << 1;
                            si_d  = sr_q[30];
                            cnt_d = cnt_q - 6'd1;
                        end
                    end
                end
            end
            SH_TAIL: begin
                if (tick) begin
                    active_d = 1'b0;
                    si_d     = 1'b0;
                    done_d   = 1'b1;
                    sh_d     = SH_IDLE;
                end
            end
            default: sh_d = SH_IDLE;
        endcase
    end

    assign o_tick   = tick;
    assign o_busy   = (sh_q != SH_IDLE);
    assign o_active = active_q;
    assign o_done   = done_q;
    assign o_sck    = sck_q;
    assign o_si     = si_q;

endmodule

// File: rtl/vs_stream_ctrl.sv
// vs_stream_ctrl
// VS10xx streaming controller: hard reset, SCI init (MODE, VOL), then SDI
// streaming of ROM words in DREQ-gated chunks, with pause, live volume and
// song changes, and loop/advance at end of song.
//   clk, rst_n         : system clock, async active-low reset
//   i_dreq             : decoder data request
//   i_song_sel         : requested song
//   i_song_len         : last word address of the current song
//   i_pause, i_loop    : pause request, repeat-at-end select
//   i_vol              : desired SCI VOL value
//   i_rdata            : ROM data, one clock after o_addr
//   o_addr, o_song     : ROM word address and bank select
//   o_xrst..o_si       : decoder pins
//   o_vol              : volume last written to the chip
//   o_busy             : low in reset hold/wait and pause
//   o_song_done        : one-clk pulse at end of song
module vs_stream_ctrl
    import vs_stream_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int WORD_W      = 16,
    parameter int ADDR_W      = 15,
    parameter int SONG_NUM    = 4,
    parameter int CHUNK_WORDS = 16,
    parameter int RESET_TICKS = 2000,
    localparam int SEL_W      = $clog2(SONG_NUM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_dreq,
    input  logic [SEL_W-1:0]  i_song_sel,
    input  logic [ADDR_W-1:0] i_song_len,
    input  logic              i_pause,
    input  logic [15:0]       i_vol,
    input  logic              i_loop,
    input  logic [WORD_W-1:0] i_rdata,
    output logic [ADDR_W-1:0] o_addr,
    output logic [SEL_W-1:0]  o_song,
    output logic              o_xrst,
    output logic              o_xcs,
    output logic              o_xdcs,
    output logic              o_sck,
    output logic              o_si,
    output logic [15:0]       o_vol,
    output logic              o_busy,
    output logic              o_song_done
);

    localparam int RCNT_W = $clog2(RESET_TICKS + 1);
    localparam int WC_W   = $clog2(CHUNK_WORDS + 1);

    state_e              state_q, state_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic                xrst_q, xrst_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SEL_W-1:0]    song_q, song_d;
    logic [SEL_W-1:0]    song_sel_q, song_sel_d;
    logic [15:0]         vol_q, vol_d;
    logic [15:0]         vol_pend_q, vol_pend_d;
    logic                pend_mode_q, pend_mode_d;
    logic                pend_vol_q, pend_vol_d;
    logic                sci_is_vol_q, sci_is_vol_d;
    logic                is_sci_q, is_sci_d;
    logic [WC_W-1:0]     words_q, words_d;
    logic                fetch_q, fetch_d;
    logic                song_done_q, song_done_d;

    logic                tick, sh_busy, sh_active, sh_done, sh_start;
    logic [31:0]         sh_data;
    logic [5:0]          sh_len;
    logic                song_req, vol_req, boundary_req;
    logic [WC_W-1:0]     words_inc;
    logic [SEL_W-1:0]    song_next;

    vs_spi_shift #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (sh_start),
        .i_data   (sh_data),
        .i_len    (sh_len),
        .o_tick   (tick),
        .o_busy   (sh_busy),
        .o_active (sh_active),
        .o_done   (sh_done),
        .o_sck    (o_sck),
        .o_si     (o_si)
    );

    // The song-change request compares against the last selection we acted
    // on, not o_song, so an automatic advance does not look like a request.
    assign song_req     = (i_song_sel != song_sel_q);
    assign vol_req      = (i_vol != vol_q);
    assign boundary_req = song_req | vol_req | i_pause;
    assign words_inc    = words_q + 1'b1;
    assign song_next    = (song_q == SEL_W'(SONG_NUM - 1)) ? '0 : song_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RESET_HOLD;
            rcnt_q       <= '0;
            xrst_q       <= 1'b0;
            addr_q       <= '0;
            song_q       <= '0;
            song_sel_q   <= '0;
            vol_q        <= '0;
            vol_pend_q   <= '0;
            pend_mode_q  <= 1'b0;
            pend_vol_q   <= 1'b0;
            sci_is_vol_q <= 1'b0;
            is_sci_q     <= 1'b0;
            words_q      <= '0;
            fetch_q      <= 1'b0;
            song_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            xrst_q       <= xrst_d;
            addr_q       <= addr_d;
            song_q       <= song_d;
            song_sel_q   <= song_sel_d;
            vol_q        <= vol_d;
            vol_pend_q   <= vol_pend_d;
            pend_mode_q  <= pend_mode_d;
            pend_vol_q   <= pend_vol_d;
            sci_is_vol_q <= sci_is_vol_d;
            is_sci_q     <= is_sci_d;
            words_q      <= words_d;
            fetch_q      <= fetch_d;
            song_done_q  <= song_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rcnt_d       = rcnt_q;
        xrst_d       = xrst_q;
        addr_d       = addr_q;
        song_d       = song_q;
        song_sel_d   = song_sel_q;
        vol_d        = vol_q;
        vol_pend_d   = vol_pend_q;
        pend_mode_d  = pend_mode_q;
        pend_vol_d   = pend_vol_q;
        sci_is_vol_d = sci_is_vol_q;
        is_sci_d     = is_sci_q;
        words_d      = words_q;
        fetch_d      = fetch_q;
        song_done_d  = 1'b0;

        case (state_q)
            ST_RESET_HOLD: begin
                if (tick) begin
                    if (rcnt_q == RCNT_W'(RESET_TICKS - 1)) begin
                        xrst_d     = 1'b1;
                        song_d     = i_song_sel;
                        song_sel_d = i_song_sel;
                        state_d    = ST_RESET_WAIT;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            ST_RESET_WAIT: begin
                if (i_dreq) state_d = ST_INIT;
            end
            ST_INIT: begin
                pend_mode_d = 1'b1;
                pend_vol_d  = 1'b1;
                state_d     = ST_SCI_WAIT;
            end
            // Pending SCI writes go out MODE first, then VOL
            ST_SCI_WAIT: begin
                if (i_dreq && !sh_busy) begin
                    is_sci_d     = 1'b1;
                    sci_is_vol_d = !pend_mode_q;
                    if (!pend_mode_q) vol_pend_d = i_vol;
                    state_d      = ST_SCI_SHIFT;
                end
            end
            ST_SCI_SHIFT: begin
                if (sh_done) begin
                    if (sci_is_vol_q) begin
                        vol_d      = vol_pend_q;
                        pend_vol_d = 1'b0;
                        state_d    = ST_DATA_WAIT;
                    end else begin
                        pend_mode_d = 1'b0;
                        state_d     = pend_vol_q ? ST_SCI_WAIT : ST_DATA_WAIT;
                    end
                end
            end
            ST_DATA_WAIT: begin
                if (song_req) begin
                    addr_d      = '0;
                    song_d      = i_song_sel;
                    song_sel_d  = i_song_sel;
                    pend_mode_d = 1'b1;
                    pend_vol_d  = 1'b1;
                    state_d     = ST_SCI_WAIT;
                end else if (vol_req) begin
                    pend_vol_d = 1'b1;
                    state_d    = ST_SCI_WAIT;
                end else if (i_pause) begin
                    state_d = ST_PAUSED;
                end else if (i_dreq) begin
                    words_d = '0;
                    fetch_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            // First clock: ROM sees o_addr. Second clock: i_rdata is valid and loads.
            ST_FETCH: begin
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else begin
                    fetch_d  = 1'b0;
                    is_sci_d = 1'b0;
                    state_d  = ST_DATA_SHIFT;
                end
            end
            ST_DATA_SHIFT: begin
                if (sh_done) begin
                    words_d = words_inc;
                    if (addr_q == i_song_len) begin
                        song_done_d = 1'b1;
                        addr_d      = '0;
                        if (i_loop) begin
                            state_d = ST_DATA_WAIT;
                        end else begin
                            song_d      = song_next;
                            pend_mode_d = 1'b1;
                            state_d     = ST_SCI_WAIT;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                        // Any pending request breaks the chunk so it is served at this word boundary
                        if (boundary_req || words_inc == WC_W'(CHUNK_WORDS)) begin
                            state_d = ST_DATA_WAIT;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end
            end
            ST_PAUSED: begin
                if (!i_pause) state_d = ST_DATA_WAIT;
            end
            default: state_d = ST_RESET_HOLD;
        endcase
    end

    always_comb begin
        sh_start = 1'b0;
        sh_data  = '0;
        sh_len   = '0;
        o_busy   = 1'b1;
        case (state_q)
            ST_SCI_WAIT: begin
                if (i_dreq && !sh_busy) begin
                    sh_start = 1'b1;
                    sh_len   = SCI_FRAME_BITS;
                    sh_data  = pend_mode_q ? sci_write(SCI_REG_MODE, MODE_INIT)
                                           : sci_write(SCI_REG_VOL, i_vol);
                end
            end
            ST_FETCH: begin
                if (fetch_q) begin
                    sh_start = 1'b1;
                    sh_len   = 6'(WORD_W);
                    sh_data  = 32'(i_rdata) << (32 - WORD_W);
                end
            end
            ST_RESET_HOLD, ST_RESET_WAIT, ST_PAUSED: o_busy = 1'b0;
            default: ;
        endcase
    end

    // Chip selects follow the shifter window; is_sci_q only changes while idle
    assign o_xcs       = !(sh_active && is_sci_q);
    assign o_xdcs      = !(sh_active && !is_sci_q);
    assign o_xrst      = xrst_q;
    assign o_addr      = addr_q;
    assign o_song      = song_q;
    assign o_vol       = vol_q;
    assign o_song_done = song_done_q;

endmodule

// File: tb/tb_vs_stream_ctrl.sv
// tb_vs_stream_ctrl
// Directed bench for vs_stream_ctrl with a decoder-side SPI capture model
// and a registered ROM model. Expected values are hand-computed constants.
module tb_vs_stream_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_dreq;
    logic [1:0]  i_song_sel;
    logic [14:0] i_song_len;
    logic        i_pause;
    logic [15:0] i_vol;
    logic        i_loop;
    logic [15:0] i_rdata;
    logic [14:0] o_addr;
    logic [1:0]  o_song;
    logic        o_xrst, o_xcs, o_xdcs, o_sck, o_si;
    logic [15:0] o_vol;
    logic        o_busy, o_song_done;

    int checks = 0;
    int errors = 0;

    vs_stream_ctrl #(
        .CLK_DIV     (2),
        .WORD_W      (16),
        .ADDR_W      (15),
        .SONG_NUM    (4),
        .CHUNK_WORDS (16),
        .RESET_TICKS (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_dreq      (i_dreq),
        .i_song_sel  (i_song_sel),
        .i_song_len  (i_song_len),
        .i_pause     (i_pause),
        .i_vol       (i_vol),
        .i_loop      (i_loop),
        .i_rdata     (i_rdata),
        .o_addr      (o_addr),
        .o_song      (o_song),
        .o_xrst      (o_xrst),
        .o_xcs       (o_xcs),
        .o_xdcs      (o_xdcs),
        .o_sck       (o_sck),
        .o_si        (o_si),
        .o_vol       (o_vol),
        .o_busy      (o_busy),
        .o_song_done (o_song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: two fixed words at the start of song 0, a tagged pattern elsewhere
    function automatic logic [15:0] rom_word(input logic [1:0] s, input logic [14:0] a);
        if (s == 2'd0 && a == 15'd0) return 16'hA5C3;
        if (s == 2'd0 && a == 15'd1) return 16'h0001;
        return {s, 1'b1, a[12:0]};
    endfunction

    always @(posedge clk) i_rdata <= rom_word(o_song, o_addr);

    // Decoder model: capture on rising SCK inside each chip-select window
    logic [31:0] sci_q[$];
    int          sci_len_q[$];
    logic [15:0] sdi_q[$];
    int          sdi_len_q[$];
    logic [14:0] addr_q[$];
    logic [31:0] sci_sr;
    logic [15:0] sdi_sr;
    int  xcs_low = 0, xdcs_low = 0;
    int  sci_starts = 0, sdi_starts = 0;
    int  done_cnt = 0, done_hi = 0, overlap_cnt = 0;
    logic prev_sck = 1'b0, prev_xcs = 1'b1, prev_xdcs = 1'b1, prev_done = 1'b0;

    always @(negedge clk) begin
        if (!o_xcs && !o_xdcs) overlap_cnt++;
        if (o_song_done) done_hi++;
        if (o_song_done && !prev_done) done_cnt++;
        if (prev_xcs && !o_xcs) begin
            sci_starts++;
            sci_sr  = '0;
            xcs_low = 0;
        end
        if (prev_xdcs && !o_xdcs) begin
            sdi_starts++;
            sdi_sr   = '0;
            xdcs_low = 0;
            addr_q.push_back(o_addr);
        end
        if (!o_xcs) xcs_low++;
        if (!o_xdcs) xdcs_low++;
        if (o_sck && !prev_sck) begin
            if (!o_xcs) sci_sr = {sci_sr[30:0], o_si};
            if (!o_xdcs) sdi_sr = {sdi_sr[14:0], o_si};
        end
        if (!prev_xcs && o_xcs) begin
            sci_q.push_back(sci_sr);
            sci_len_q.push_back(xcs_low);
        end
        if (!prev_xdcs && o_xdcs) begin
            sdi_q.push_back(sdi_sr);
            sdi_len_q.push_back(xdcs_low);
        end
        prev_sck  = o_sck;
        prev_xcs  = o_xcs;
        prev_xdcs = o_xdcs;
        prev_done = o_song_done;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic dreq, input logic pause, input logic loop,
                                 input logic [15:0] vol, input logic [1:0] sel,
                                 input logic [14:0] len);
        i_dreq     = dreq;
        i_pause    = pause;
        i_loop     = loop;
        i_vol      = vol;
        i_song_sel = sel;
        i_song_len = len;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        int last;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h3030, 2'd0, 15'd100);
        waitCycles(3);
        $display("[TB] reset values");
        checkOutput("rst_xrst", o_xrst, 0);
        checkOutput("rst_xcs", o_xcs, 1);
        checkOutput("rst_xdcs", o_xdcs, 1);
        checkOutput("rst_sck", o_sck, 0);
        checkOutput("rst_si", o_si, 0);
        checkOutput("rst_addr", o_addr, 0);
        checkOutput("rst_song", o_song, 0);
        checkOutput("rst_vol", o_vol, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_song_done, 0);

        // Reset hold: 10 ticks at 2 clks each
        rst_n = 1'b1;
        n = 0;
        while (!o_xrst && n < 200) begin @(negedge clk); n++; end
        checkOutput("xrst_clks", n, 20);
        waitCycles(50);
        checkOutput("wait_busy", o_busy, 0);
        checkOutput("wait_no_sci", sci_starts, 0);

        // Init frames; drop DREQ once the second frame is under way
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h3030, 2'd0, 15'd100);
        n = 0;
        while (sci_starts < 2 && n < 2000) begin @(negedge clk); n++; end
        i_dreq = 1'b0;
        n = 0;
        while (sci_q.size() < 2 && n < 2000) begin @(negedge clk); n++; end
        checkOutput("init_timeout", n < 2000, 1);
        waitCycles(5);
        checkOutput("init_mode", sci_q[0], 32'h02000804);
        checkOutput("init_vol", sci_q[1], 32'h020B3030);
        checkOutput("init_mode_len", sci_len_q[0], 130);
        checkOutput("init_vol_len", sci_len_q[1], 130);
        checkOutput("init_o_vol", o_vol, 16'h3030);
        waitCycles(200);
        checkOutput("idle_no_sdi", sdi_starts, 0);
        checkOutput("idle_busy", o_busy, 1);

        // One chunk: DREQ dropped right after the first word starts
        i_dreq = 1'b1;
        n = 0;
        while (sdi_starts < 1 && n < 500) begin @(negedge clk); n++; end
        i_dreq = 1'b0;
        n = 0;
        while (sdi_q.size() < 16 && n < 4000) begin @(negedge clk); n++; end
        waitCycles(400);
        checkOutput("chunk_words", sdi_q.size(), 16);
        checkOutput("chunk_xdcs_idle", o_xdcs, 1);
        checkOutput("chunk_addr", o_addr, 16);
        checkOutput("word0", sdi_q[0], 16'hA5C3);
        checkOutput("word1", sdi_q[1], 16'h0001);
        checkOutput("word_len", sdi_len_q[0], 66);
        checkOutput("addr0", addr_q[0], 0);
        checkOutput("addr1", addr_q[1], 1);
        checkOutput("addr2", addr_q[2], 2);

        // Pause mid-word
        i_dreq = 1'b1;
        n = 0;
        while (sdi_starts < 17 && n < 500) begin @(negedge clk); n++; end
        i_pause = 1'b1;
        n = 0;
        while (o_busy && n < 500) begin @(negedge clk); n++; end
        checkOutput("pause_entered", o_busy, 0);
        waitCycles(300);
        checkOutput("pause_words", sdi_q.size(), 17);
        checkOutput("pause_addr", o_addr, 17);
        checkOutput("pause_xdcs", o_xdcs, 1);
        i_pause = 1'b0;
        n = 0;
        while (sdi_q.size() < 18 && n < 500) begin @(negedge clk); n++; end
        checkOutput("resume_addr", addr_q[17], 17);
        checkOutput("resume_word", sdi_q[17], {16'h0, rom_word(2'd0, 15'd17)});

        // Volume change mid-stream
        i_vol = 16'h2020;
        n = 0;
        while (sci_q.size() < 3 && n < 1000) begin @(negedge clk); n++; end
        waitCycles(10);
        checkOutput("vol_frame", sci_q[2], 32'h020B2020);
        checkOutput("vol_frame_len", sci_len_q[2], 130);
        checkOutput("vol_out", o_vol, 16'h2020);
        last = sdi_q.size();
        n = 0;
        while (sdi_q.size() <= last && n < 1000) begin @(negedge clk); n++; end
        checkOutput("vol_stream_on", sdi_q.size() > last, 1);
        checkOutput("vol_addr_seq", addr_q[last], addr_q[last - 1] + 15'd1);
        checkOutput("no_overlap", overlap_cnt, 0);

        // Async reset during a data word
        n = 0;
        while (o_xdcs && n < 500) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("areset_xdcs", o_xdcs, 1);
        checkOutput("areset_sck", o_sck, 0);
        checkOutput("areset_si", o_si, 0);
        checkOutput("areset_xrst", o_xrst, 0);
        checkOutput("areset_addr", o_addr, 0);

        // Short song: advance, then loop
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h3030, 2'd0, 15'd3);
        waitCycles(3);
        sci_q.delete(); sci_len_q.delete(); sdi_q.delete(); sdi_len_q.delete(); addr_q.delete();
        done_cnt = 0;
        done_hi  = 0;
        rst_n = 1'b1;
        n = 0;
        while (done_cnt < 1 && n < 5000) begin @(negedge clk); n++; end
        checkOutput("adv_words", sdi_q.size(), 4);
        checkOutput("adv_song", o_song, 1);
        checkOutput("adv_addr3", addr_q[3], 3);
        n = 0;
        while (sci_q.size() < 3 && n < 1000) begin @(negedge clk); n++; end
        checkOutput("adv_mode", sci_q[2], 32'h02000804);
        i_loop = 1'b1;
        n = 0;
        while (done_cnt < 2 && n < 5000) begin @(negedge clk); n++; end
        checkOutput("loop_song", o_song, 1);
        n = 0;
        while (sdi_q.size() < 9 && n < 1000) begin @(negedge clk); n++; end
        checkOutput("loop_wrap", addr_q[8], 0);
        checkOutput("song1_word0", sdi_q[4], {16'h0, rom_word(2'd1, 15'd0)});
        checkOutput("loop_no_mode", sci_q.size(), 3);
        checkOutput("done_pulse_w", done_hi, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
